// File: rtl/fifo_flags_pkg.sv
// fifo_flags_pkg: shared constants helper and parameter legality checks for the fifo family
`ifndef FIFO_FLAGS_PKG_SV
`define FIFO_FLAGS_PKG_SV
package fifo_flags_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage
`define FIFO_FLAGS_CHECK(D, AF, AE) \
  if ((D) < 2 || ((D) & ((D) - 1)) != 0) begin : g_bad_depth \
    $error("fifo_flags: DEPTH must be a power of two and at least 2"); \
  end \
  if ((AF) < 1 || (AF) > (D)) begin : g_bad_af \
    $error("fifo_flags: AF_LEVEL must be in 1..DEPTH"); \
  end \
  if ((AE) < 0 || (AE) > (D) - 1) begin : g_bad_ae \
    $error("fifo_flags: AE_LEVEL must be in 0..DEPTH-1"); \
  end
`endif

// File: rtl/fifo_flags_if.sv
// fifo_flags_if: producer/consumer handshake and status bundle of the flagged fifo
interface fifo_flags_if import fifo_flags_pkg::*; #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) ();
  localparam int AW = clog2(DEPTH);
  logic          push;
  logic [W-1:0]  in;
  logic          pop;
  logic          clr_err;
  logic [W-1:0]  data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  modport master (
    output push, in, pop, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  push, in, pop, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flags_ram.sv
// fifo_ram: DEPTH x W storage, synchronous write port, asynchronous read port, no reset
module fifo_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  // write the addressed entry on an accepted push
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: fwft synchronous fifo with occupancy count, threshold flags and sticky error flags
module fifo_flags import fifo_flags_pkg::*; #(
  parameter int W        = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_flags_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C   = (AW+1)'(AE_LEVEL);

  `FIFO_FLAGS_CHECK(DEPTH, AF_LEVEL, AE_LEVEL)

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_unf;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_push_rej;
  logic          w_pop_rej;

  // a full fifo still takes a push when the head is popped in the same cycle; an empty one never pops
  always_comb begin
    w_push_ok  = bus.push && (r_count != FULL_C || bus.pop);
    w_pop_ok   = bus.pop && r_count != '0;
    w_push_rej = bus.push && !w_push_ok;
    w_pop_rej  = bus.pop && !w_pop_ok;
  end

  // pointers, occupancy and sticky errors; a new error wins over clr_err
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
      r_ovf   <= w_push_rej | (r_ovf & ~bus.clr_err);
      r_unf   <= w_pop_rej | (r_unf & ~bus.clr_err);
    end

  fifo_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in),
    .i_raddr (r_rd_ptr),
    .o_rdata (bus.data_out)
  );

  assign bus.count        = r_count;
  assign bus.full         = r_count == FULL_C;
  assign bus.empty        = r_count == '0;
  assign bus.almost_full  = r_count >= AF_C;
  assign bus.almost_empty = r_count <= AE_C;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;
endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO for the UART datapath; the successor of the fixed 8x8 buffer. It sits between the byte producer (banner/message ROM sequencer or RX deserialiser) and its consumer (TX serialiser or host logic). It adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Simultaneous push and pop are defined in every state, including full and empty.

## Interface
- W, 8: data width in bits.
- DEPTH, 16: number of entries; power of two, at least 2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- push  in  1  write request; in is sampled on the same edge.
- in  in  W  write data.
- pop  in  1  read request; consumes the word currently on data_out.
- clr_err  in  1  synchronous clear of overflow and underflow.
- data_out  out  W  head word, first-word-fall-through; valid only while empty=0.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1  current occupancy, 0..DEPTH; AW = log2(DEPTH).
- overflow  out  1  sticky; a push was rejected.
- underflow  out  1  sticky; a pop was rejected.

## Operation
- Storage:
  - DEPTH x W array.
  - Write pointer wr_ptr and read pointer rd_ptr, each AW bits wide.
  - Pointers wrap modulo DEPTH by natural overflow.
- Status: count is a registered AW+1-bit counter; every flag is decoded combinationally from count.
- Push acceptance: a push is accepted if count < DEPTH, or if count == DEPTH and pop is also asserted in the same cycle.
- Pop acceptance: a pop is accepted only if count > 0. A pop with count == 0 is rejected even when push is asserted in the same cycle; there is no bypass.
- Accepted push: mem[wr_ptr] <= in; wr_ptr increments.
- Accepted pop: rd_ptr increments.
- Count update: +1 on push only, -1 on pop only, unchanged when both are accepted.
- Rejected push: memory, wr_ptr and count are unchanged; overflow <= 1.
- Rejected pop: rd_ptr and count are unchanged; underflow <= 1.
- Error flag precedence: clr_err clears overflow and underflow unless a new error occurs in the same cycle; set wins over clear.
- data_out is mem[rd_ptr], read asynchronously. It holds its last value while empty, and that value is don't-care.
- Reset values:
  - count=0, wr_ptr=0, rd_ptr=0.
  - empty=1, full=0, almost_full=0 (since AF_LEVEL >= 1), almost_empty=1.
  - overflow=0, underflow=0.
  - Memory contents are not reset.
- Reset asserted mid-operation: all contents are discarded immediately and asynchronously. The outputs go to their reset values without waiting for a clock edge.

## Timing
- Push at edge k: empty falls and data_out shows the written word right after edge k. Write-to-read latency is therefore 1 cycle.
- Pop at edge k: data_out advances to the next word right after edge k.
- Flags and count change only on clock edges or on reset, never combinationally from push or pop.
- Full with push and pop at the same edge: the old head is consumed, the new word is written into the freed slot, full stays 1, and count stays DEPTH.
- Empty with push and pop at the same edge: the word is stored, count becomes 1, and underflow is set.
- Wrap-around: after DEPTH pushes and DEPTH pops, both pointers return to 0 and data order is preserved.

## Structure
- Shared header, include-guarded per team practice, holding:
  - the clog2 constant function, used to compute AW;
  - parameter legality checks for DEPTH, AF_LEVEL and AE_LEVEL, each producing an elaboration-time error when violated.
- One natural sub-module, fifo_ram:
  - DEPTH x W, one synchronous write port, one asynchronous read port;
  - shared with future async/multi-channel FIFO variants.
- fifo_flags contains the pointers, count, acceptance logic and flag decode.

## Test plan
- Reset then fill, W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2: push 0x00..0x0F.
  - almost_empty falls after the 3rd push.
  - almost_full rises after the 14th push.
  - full=1 and count=16 after the 16th push.
- Push 0xAA into a full FIFO with pop=0: overflow=1, count=16, and draining the FIFO returns 0x00..0x0F unchanged.
- Pop into an empty FIFO: underflow=1 and count=0. Then pulse clr_err: both error flags are 0 on the next cycle.
- Full FIFO, push 0x55 with pop in the same cycle: old head 0x00 is consumed, count stays 16, and 0x55 appears last when drained.
- Empty FIFO, push 0x33 with pop in the same cycle: count=1, data_out=0x33, underflow=1.
- Stream 40 words with random push/pop against a reference queue: data order, count and flags always match the model, across pointer wrap. Assert reset mid-stream: count=0 and empty=1 immediately, without waiting for a clock edge.
